// File: rtl/fifo_scoreboard.sv
// In-order scoreboard: per channel, queues every pushed word and checks each popped word against the queue head.
// One-cycle latency with all outputs registered; strobes are only observed, so the block never applies backpressure.
module fifo_scoreboard #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int N_CH   = 1,
    parameter int CNT_W  = 16,
    parameter int BYPASS = 0
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst,
    input  logic                                       i_cg,
    input  logic                                       i_clear,
    input  logic [N_CH-1:0]                            i_pushed,
    input  logic [N_CH*WIDTH-1:0]                      i_pushData,
    input  logic [N_CH-1:0]                            i_popped,
    input  logic [N_CH*WIDTH-1:0]                      i_popData,
    output logic                                       o_err,
    output logic [N_CH-1:0]                            o_errCh,
    output logic [1:0]                                 o_firstErrCode,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] o_firstErrCh,
    output logic [WIDTH-1:0]                           o_firstErrExp,
    output logic [WIDTH-1:0]                           o_firstErrAct,
    output logic [N_CH*$clog2(DEPTH+1)-1:0]            o_nEntries,
    output logic [N_CH-1:0]                            o_empty,
    output logic [N_CH*CNT_W-1:0]                      o_nPushed,
    output logic [N_CH*CNT_W-1:0]                      o_nPopped,
    output logic [N_CH*CNT_W-1:0]                      o_nErr
);

    localparam int   PW  = $clog2(DEPTH);
    localparam int   CW  = $clog2(DEPTH + 1);
    localparam int   CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic BYP = (BYPASS != 0);

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_MIS   = 2'd1;
    localparam logic [1:0] ERR_UNDER = 2'd2;
    localparam logic [1:0] ERR_OVER  = 2'd3;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    logic [N_CH-1:0][1:0]       w_chCode;
    logic [N_CH-1:0][WIDTH-1:0] w_chExp;
    logic [N_CH-1:0][WIDTH-1:0] w_chAct;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [PW-1:0]    r_wptr;
        logic [PW-1:0]    r_rptr;
        logic [CW-1:0]    r_cnt;
        logic             r_errCh;
        logic [CNT_W-1:0] r_nPushed;
        logic [CNT_W-1:0] r_nPopped;
        logic [CNT_W-1:0] r_nErr;

        logic             w_push;
        logic             w_pop;
        logic             w_empty;
        logic             w_full;
        logic             w_popHit;
        logic             w_bypass;
        logic             w_under;
        logic             w_over;
        logic             w_mis;
        logic             w_wr;
        logic             w_err;
        logic [WIDTH-1:0] w_pushD;
        logic [WIDTH-1:0] w_popD;
        logic [WIDTH-1:0] w_head;

        assign w_push   = i_pushed[c];
        assign w_pop    = i_popped[c];
        assign w_pushD  = i_pushData[c*WIDTH +: WIDTH];
        assign w_popD   = i_popData[c*WIDTH +: WIDTH];
        assign w_head   = r_mem[r_rptr];
        assign w_empty  = (r_cnt == '0);
        assign w_full   = (r_cnt == CW'(DEPTH));

        // An empty-queue pop can only be satisfied by a same-cycle push in bypass mode.
        assign w_popHit = w_pop && !w_empty;
        assign w_bypass = BYP && w_pop && w_empty && w_push;
        assign w_under  = w_pop && w_empty && !w_bypass;
        assign w_wr     = w_push && !w_bypass && (!w_full || w_popHit);
        assign w_over   = w_push && w_full && !w_popHit;
        assign w_mis    = (w_popHit && (w_popD != w_head)) || (w_bypass && (w_popD != w_pushD));
        assign w_err    = w_mis || w_under || w_over;

        assign w_chCode[c] = w_mis ? ERR_MIS : w_under ? ERR_UNDER : w_over ? ERR_OVER : ERR_NONE;
        // Overflow and underflow have no meaningful expected word, so they report zero.
        assign w_chExp[c]  = w_popHit ? w_head : (w_bypass ? w_pushD : '0);
        assign w_chAct[c]  = w_over ? w_pushD : w_popD;

        always_ff @(posedge i_clk) begin
            if (i_cg && !i_clear && w_wr) begin
                r_mem[r_wptr] <= w_pushD;
            end
        end

        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                r_wptr    <= '0;
                r_rptr    <= '0;
                r_cnt     <= '0;
                r_errCh   <= 1'b0;
                r_nPushed <= '0;
                r_nPopped <= '0;
                r_nErr    <= '0;
            end else if (i_cg) begin
                if (i_clear) begin
                    r_wptr    <= '0;
                    r_rptr    <= '0;
                    r_cnt     <= '0;
                    r_errCh   <= 1'b0;
                    r_nPushed <= '0;
                    r_nPopped <= '0;
                    r_nErr    <= '0;
                end else begin
                    if (w_wr) begin
                        r_wptr <= ptr_next(r_wptr);
                    end
                    if (w_popHit) begin
                        r_rptr <= ptr_next(r_rptr);
                    end
                    r_cnt <= r_cnt + CW'(w_wr) - CW'(w_popHit);
                    if (w_wr || w_bypass) begin
                        r_nPushed <= sat_inc(r_nPushed);
                    end
                    if (w_pop) begin
                        r_nPopped <= sat_inc(r_nPopped);
                    end
                    if (w_err) begin
                        r_errCh <= 1'b1;
                        r_nErr  <= sat_inc(r_nErr);
                    end
                end
            end
        end

        assign o_errCh[c]                 = r_errCh;
        assign o_empty[c]                 = w_empty;
        assign o_nEntries[c*CW +: CW]     = r_cnt;
        assign o_nPushed[c*CNT_W +: CNT_W] = r_nPushed;
        assign o_nPopped[c*CNT_W +: CNT_W] = r_nPopped;
        assign o_nErr[c*CNT_W +: CNT_W]    = r_nErr;
    end

    logic             w_selHit;
    logic [CHW-1:0]   w_selCh;
    logic [1:0]       w_selCode;
    logic [WIDTH-1:0] w_selExp;
    logic [WIDTH-1:0] w_selAct;

    // Scan from the top down so the lowest erring channel is the one left selected.
    always_comb begin
        w_selHit  = 1'b0;
        w_selCh   = '0;
        w_selCode = ERR_NONE;
        w_selExp  = '0;
        w_selAct  = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (w_chCode[c] != ERR_NONE) begin
                w_selHit  = 1'b1;
                w_selCh   = CHW'(c);
                w_selCode = w_chCode[c];
                w_selExp  = w_chExp[c];
                w_selAct  = w_chAct[c];
            end
        end
    end

    logic [1:0]       r_firstCode;
    logic [CHW-1:0]   r_firstCh;
    logic [WIDTH-1:0] r_firstExp;
    logic [WIDTH-1:0] r_firstAct;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_firstCode <= ERR_NONE;
            r_firstCh   <= '0;
            r_firstExp  <= '0;
            r_firstAct  <= '0;
        end else if (i_cg) begin
            if (i_clear) begin
                r_firstCode <= ERR_NONE;
                r_firstCh   <= '0;
                r_firstExp  <= '0;
                r_firstAct  <= '0;
            end else if (r_firstCode == ERR_NONE && w_selHit) begin
                r_firstCode <= w_selCode;
                r_firstCh   <= w_selCh;
                r_firstExp  <= w_selExp;
                r_firstAct  <= w_selAct;
            end
        end
    end

    assign o_err          = |o_errCh;
    assign o_firstErrCode = r_firstCode;
    assign o_firstErrCh   = r_firstCh;
    assign o_firstErrExp  = r_firstExp;
    assign o_firstErrAct  = r_firstAct;

endmodule

// File: tb/tb_fifo_scoreboard.sv
// Bench for fifo_scoreboard: two instances (DEPTH=4/no bypass/4-bit counters and DEPTH=5/bypass/16-bit counters)
// share one stimulus stream; directed table rows, a saturation sequence, then random traffic against a queue model.
module tb_fifo_scoreboard;

    localparam int NC = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            cg;
    logic            clear;
    logic [NC-1:0]   pushed;
    logic [NC-1:0]   popped;
    logic [NC*8-1:0] push_d;
    logic [NC*8-1:0] pop_d;

    logic        o0_err,   o1_err;
    logic [2:0]  o0_errCh, o1_errCh;
    logic [1:0]  o0_code,  o1_code;
    logic [1:0]  o0_fch,   o1_fch;
    logic [7:0]  o0_fexp,  o1_fexp;
    logic [7:0]  o0_fact,  o1_fact;
    logic [8:0]  o0_nent,  o1_nent;
    logic [2:0]  o0_empty, o1_empty;
    logic [11:0] o0_np, o0_nq, o0_ne;
    logic [47:0] o1_np, o1_nq, o1_ne;

    fifo_scoreboard #(.WIDTH(8), .DEPTH(4), .N_CH(NC), .CNT_W(4), .BYPASS(0)) u0 (
        .i_clk(clk), .i_rst(rst_n), .i_cg(cg), .i_clear(clear),
        .i_pushed(pushed), .i_pushData(push_d), .i_popped(popped), .i_popData(pop_d),
        .o_err(o0_err), .o_errCh(o0_errCh), .o_firstErrCode(o0_code), .o_firstErrCh(o0_fch),
        .o_firstErrExp(o0_fexp), .o_firstErrAct(o0_fact), .o_nEntries(o0_nent), .o_empty(o0_empty),
        .o_nPushed(o0_np), .o_nPopped(o0_nq), .o_nErr(o0_ne)
    );

    fifo_scoreboard #(.WIDTH(8), .DEPTH(5), .N_CH(NC), .CNT_W(16), .BYPASS(1)) u1 (
        .i_clk(clk), .i_rst(rst_n), .i_cg(cg), .i_clear(clear),
        .i_pushed(pushed), .i_pushData(push_d), .i_popped(popped), .i_popData(pop_d),
        .o_err(o1_err), .o_errCh(o1_errCh), .o_firstErrCode(o1_code), .o_firstErrCh(o1_fch),
        .o_firstErrExp(o1_fexp), .o_firstErrAct(o1_fact), .o_nEntries(o1_nent), .o_empty(o1_empty),
        .o_nPushed(o1_np), .o_nPopped(o1_nq), .o_nErr(o1_ne)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got=%0h want=%0h at %0t", nm, idx, act, exp, $time);
        end
    endtask

    // Reference model: one queue per (instance, channel), index d*NC+c.
    logic [7:0] mq [2*NC][$];
    int m_np [2*NC];
    int m_nq [2*NC];
    int m_ne [2*NC];
    int m_errch [2];
    int m_code [2];
    int m_fch [2];
    int m_fexp [2];
    int m_fact [2];

    function automatic int sat(input int v, input int mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    task automatic model_reset_one(input int d);
        for (int c = 0; c < NC; c++) begin
            mq[d*NC+c].delete();
            m_np[d*NC+c] = 0;
            m_nq[d*NC+c] = 0;
            m_ne[d*NC+c] = 0;
        end
        m_errch[d] = 0; m_code[d] = 0; m_fch[d] = 0; m_fexp[d] = 0; m_fact[d] = 0;
    endtask

    task automatic model_reset();
        model_reset_one(0);
        model_reset_one(1);
    endtask

    task automatic model_step(input int d);
        int depth, cmax, k, pd, qd, ecode, eexp, eact;
        bit byp, push_left;
        depth = (d == 0) ? 4 : 5;
        cmax  = (d == 0) ? 15 : 65535;
        byp   = (d == 1);
        if (!cg) return;
        if (clear) begin
            model_reset_one(d);
            return;
        end
        for (int c = 0; c < NC; c++) begin
            k = d*NC + c;
            pd = int'(push_d[c*8 +: 8]);
            qd = int'(pop_d[c*8 +: 8]);
            push_left = pushed[c];
            ecode = 0; eexp = 0; eact = 0;
            if (popped[c]) begin
                m_nq[k] = sat(m_nq[k], cmax);
                if (mq[k].size() > 0) begin
                    eexp = int'(mq[k].pop_front());
                    if (eexp != qd) begin ecode = 1; eact = qd; end
                end else if (byp && pushed[c]) begin
                    push_left = 1'b0;
                    m_np[k] = sat(m_np[k], cmax);
                    eexp = pd;
                    if (pd != qd) begin ecode = 1; eact = qd; end
                end else begin
                    ecode = 2; eexp = 0; eact = qd;
                end
            end
            if (push_left) begin
                if (mq[k].size() < depth) begin
                    mq[k].push_back(8'(pd));
                    m_np[k] = sat(m_np[k], cmax);
                end else begin
                    ecode = 3; eexp = 0; eact = pd;
                end
            end
            if (ecode != 0) begin
                m_errch[d] |= (1 << c);
                m_ne[k] = sat(m_ne[k], cmax);
                if (m_code[d] == 0) begin
                    m_code[d] = ecode; m_fch[d] = c; m_fexp[d] = eexp; m_fact[d] = eact;
                end
            end
        end
    endtask

    task automatic compare_model(input int d);
        int k, e_empty;
        e_empty = 0;
        chk("errCh", d, (d == 0) ? int'(o0_errCh) : int'(o1_errCh), m_errch[d]);
        chk("err",   d, (d == 0) ? int'(o0_err)   : int'(o1_err),   int'(m_errch[d] != 0));
        chk("code",  d, (d == 0) ? int'(o0_code)  : int'(o1_code),  m_code[d]);
        chk("fch",   d, (d == 0) ? int'(o0_fch)   : int'(o1_fch),   m_fch[d]);
        chk("fexp",  d, (d == 0) ? int'(o0_fexp)  : int'(o1_fexp),  m_fexp[d]);
        chk("fact",  d, (d == 0) ? int'(o0_fact)  : int'(o1_fact),  m_fact[d]);
        for (int c = 0; c < NC; c++) begin
            k = d*NC + c;
            if (mq[k].size() == 0) e_empty |= (1 << c);
            chk("nEntries", k, (d == 0) ? int'(o0_nent[c*3 +: 3]) : int'(o1_nent[c*3 +: 3]), mq[k].size());
            chk("nPushed",  k, (d == 0) ? int'(o0_np[c*4 +: 4]) : int'(o1_np[c*16 +: 16]), m_np[k]);
            chk("nPopped",  k, (d == 0) ? int'(o0_nq[c*4 +: 4]) : int'(o1_nq[c*16 +: 16]), m_nq[k]);
            chk("nErr",     k, (d == 0) ? int'(o0_ne[c*4 +: 4]) : int'(o1_ne[c*16 +: 16]), m_ne[k]);
        end
        chk("empty", d, (d == 0) ? int'(o0_empty) : int'(o1_empty), e_empty);
    endtask

    // Directed rows: stimulus, then expectations for u0 (ch0 counters) plus u1 code/ch0 occupancy.
    typedef struct {
        int cg, clr, push, pd, pop, qd;
        int errch, code, fch, fexp, fact, nent0, empty, np0, nq0, ne0, u1code, u1nent0;
    } vec_t;

    vec_t tv[$];

    task automatic add(input int cg_, clr, push, pd, pop, qd, errch, code, fch, fexp, fact,
                       nent0, empty, np0, nq0, ne0, u1code, u1nent0);
        vec_t v;
        v.cg = cg_; v.clr = clr; v.push = push; v.pd = pd; v.pop = pop; v.qd = qd;
        v.errch = errch; v.code = code; v.fch = fch; v.fexp = fexp; v.fact = fact;
        v.nent0 = nent0; v.empty = empty; v.np0 = np0; v.nq0 = nq0; v.ne0 = ne0;
        v.u1code = u1code; v.u1nent0 = u1nent0;
        tv.push_back(v);
    endtask

    task automatic idle();
        cg = 1'b1; clear = 1'b0; pushed = '0; popped = '0; push_d = '0; pop_d = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();

        //  cg clr push pd         pop qd        | errch code fch fexp fact nent empty np nq ne u1code u1nent
        add(1, 0, 1, 'hA0,       0, 0,         0, 0, 0, 0,    0,    1, 6, 1, 0, 0, 0, 1);
        add(1, 0, 1, 'hA1,       0, 0,         0, 0, 0, 0,    0,    2, 6, 2, 0, 0, 0, 2);
        add(1, 0, 1, 'hA2,       0, 0,         0, 0, 0, 0,    0,    3, 6, 3, 0, 0, 0, 3);
        add(1, 0, 1, 'hA3,       0, 0,         0, 0, 0, 0,    0,    4, 6, 4, 0, 0, 0, 4);
        add(1, 0, 0, 0,          1, 'hA0,      0, 0, 0, 0,    0,    3, 6, 4, 1, 0, 0, 3);
        add(1, 0, 0, 0,          1, 'hA1,      0, 0, 0, 0,    0,    2, 6, 4, 2, 0, 0, 2);
        add(1, 0, 0, 0,          1, 'hA2,      0, 0, 0, 0,    0,    1, 6, 4, 3, 0, 0, 1);
        add(1, 0, 0, 0,          1, 'hA3,      0, 0, 0, 0,    0,    0, 7, 4, 4, 0, 0, 0);
        add(1, 1, 0, 0,          0, 0,         0, 0, 0, 0,    0,    0, 7, 0, 0, 0, 0, 0);
        add(1, 0, 1, 'h11,       0, 0,         0, 0, 0, 0,    0,    1, 6, 1, 0, 0, 0, 1);
        add(1, 0, 0, 0,          1, 'h12,      1, 1, 0, 'h11, 'h12, 0, 7, 1, 1, 1, 1, 0);
        add(1, 1, 0, 0,          0, 0,         0, 0, 0, 0,    0,    0, 7, 0, 0, 0, 0, 0);
        add(1, 0, 1, 'hB0,       0, 0,         0, 0, 0, 0,    0,    1, 6, 1, 0, 0, 0, 1);
        add(1, 0, 1, 'hB1,       0, 0,         0, 0, 0, 0,    0,    2, 6, 2, 0, 0, 0, 2);
        add(1, 0, 1, 'hB2,       0, 0,         0, 0, 0, 0,    0,    3, 6, 3, 0, 0, 0, 3);
        add(1, 0, 1, 'hB3,       0, 0,         0, 0, 0, 0,    0,    4, 6, 4, 0, 0, 0, 4);
        add(1, 0, 1, 'hB4,       1, 'hB0,      0, 0, 0, 0,    0,    4, 6, 5, 1, 0, 0, 4);
        add(1, 0, 1, 'hB5,       0, 0,         1, 3, 0, 0,    'hB5, 4, 6, 5, 1, 1, 0, 5);
        add(1, 1, 0, 0,          0, 0,         0, 0, 0, 0,    0,    0, 7, 0, 0, 0, 0, 0);
        add(1, 0, 1, 'h5A,       1, 'h5A,      1, 2, 0, 0,    'h5A, 1, 6, 1, 1, 1, 0, 0);
        add(1, 1, 0, 0,          0, 0,         0, 0, 0, 0,    0,    0, 7, 0, 0, 0, 0, 0);
        add(1, 0, 6, 'h322100,   0, 0,         0, 0, 0, 0,    0,    0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0,          6, 'h332200,  6, 1, 1, 'h21, 'h22, 0, 7, 0, 0, 0, 1, 0);
        add(1, 1, 0, 0,          0, 0,         0, 0, 0, 0,    0,    0, 7, 0, 0, 0, 0, 0);
        add(0, 0, 1, 'h77,       0, 0,         0, 0, 0, 0,    0,    0, 7, 0, 0, 0, 0, 0);
        add(1, 0, 1, 'h77,       0, 0,         0, 0, 0, 0,    0,    1, 6, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0,          0, 0,         0, 0, 0, 0,    0,    1, 6, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0,          1, 'h78,      0, 0, 0, 0,    0,    1, 6, 1, 0, 0, 0, 1);
        add(1, 0, 0, 0,          1, 'h78,      1, 1, 0, 'h77, 'h78, 0, 7, 1, 1, 1, 1, 0);
        add(1, 1, 1, 'h99,       1, 'h99,      0, 0, 0, 0,    0,    0, 7, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0,          1, 'h44,      1, 2, 0, 0,    'h44, 0, 7, 0, 1, 1, 2, 0);
        add(1, 1, 0, 0,          0, 0,         0, 0, 0, 0,    0,    0, 7, 0, 0, 0, 0, 0);

        #12;
        model_reset();
        compare_model(0);
        compare_model(1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            @(negedge clk);
            cg     = tv[i].cg[0];
            clear  = tv[i].clr[0];
            pushed = 3'(tv[i].push);
            push_d = 24'(tv[i].pd);
            popped = 3'(tv[i].pop);
            pop_d  = 24'(tv[i].qd);
            @(posedge clk);
            #1;
            chk("tv_errCh",  i, int'(o0_errCh), tv[i].errch);
            chk("tv_err",    i, int'(o0_err),   int'(tv[i].errch != 0));
            chk("tv_code",   i, int'(o0_code),  tv[i].code);
            chk("tv_fch",    i, int'(o0_fch),   tv[i].fch);
            chk("tv_fexp",   i, int'(o0_fexp),  tv[i].fexp);
            chk("tv_fact",   i, int'(o0_fact),  tv[i].fact);
            chk("tv_nent0",  i, int'(o0_nent[2:0]), tv[i].nent0);
            chk("tv_empty",  i, int'(o0_empty), tv[i].empty);
            chk("tv_np0",    i, int'(o0_np[3:0]), tv[i].np0);
            chk("tv_nq0",    i, int'(o0_nq[3:0]), tv[i].nq0);
            chk("tv_ne0",    i, int'(o0_ne[3:0]), tv[i].ne0);
            chk("tv_u1code", i, int'(o1_code),  tv[i].u1code);
            chk("tv_u1nent", i, int'(o1_nent[2:0]), tv[i].u1nent0);
        end

        // 20 accepted push/pop pairs on ch0: the 4-bit counters must stick at 15.
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            idle();
            pushed[0] = (i < 20);
            push_d[7:0] = 8'(8'h40 + i);
            popped[0] = (i > 0);
            pop_d[7:0] = 8'(8'h40 + i - 1);
        end
        @(negedge clk);
        idle();
        #1;
        chk("sat_np0",  0, int'(o0_np[3:0]),   15);
        chk("sat_nq0",  0, int'(o0_nq[3:0]),   15);
        chk("sat_err0", 0, int'(o0_err),       0);
        chk("sat_np1",  1, int'(o1_np[15:0]),  20);
        chk("sat_nq1",  1, int'(o1_nq[15:0]),  20);
        chk("sat_err1", 1, int'(o1_err),       0);
        chk("sat_nent", 1, int'(o1_nent[2:0]), 0);

        clear = 1'b1;
        @(posedge clk);
        #1;
        model_reset();

        for (int i = 0; i < 10000; i++) begin
            int n;
            bit ill;
            if (i == 5000) begin
                @(negedge clk);
                idle();
                rst_n = 1'b0;
                #2;
                model_reset();
                compare_model(0);
                compare_model(1);
                @(negedge clk);
                rst_n = 1'b1;
            end
            @(negedge clk);
            cg    = ($urandom_range(0, 15) != 0);
            clear = ($urandom_range(0, 399) == 0);
            for (int c = 0; c < NC; c++) begin
                n   = mq[c].size();
                ill = ($urandom_range(0, 127) == 0);
                popped[c] = ($urandom_range(0, 1) == 1) && (n > 0 || ill);
                pushed[c] = ($urandom_range(0, 1) == 1) && (n < 4 || popped[c] || ill);
                push_d[c*8 +: 8] = 8'($urandom);
                pop_d[c*8 +: 8]  = (n > 0) ? mq[c][0] : 8'($urandom);
                if ($urandom_range(0, 63) == 0) pop_d[c*8] = ~pop_d[c*8];
            end
            @(posedge clk);
            #1;
            model_step(0);
            model_step(1);
            compare_model(0);
            compare_model(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
